// File: rtl/hdd_step_pkg.sv
// Shared constants for the HDD step pulse generator.
// Macro HDD_STEP_QUEUE_EN selects the multi-entry request FIFO over the single holding register.
package hdd_step_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DIR_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE     = 2'd2;
    localparam logic [1:0] ST_RECOVERY  = 2'd3;

    // Default timing in 300 MHz clocks
    localparam int unsigned DEF_PULSE_WIDTH = 3000;
    localparam int unsigned DEF_DIR_SETUP   = 300;
    localparam int unsigned DEF_RECOVERY    = 1500;

`ifdef HDD_STEP_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

endpackage

// File: rtl/hdd_step_queue.sv
// Step-request FIFO of direction bits with same-cycle push/pop.
// DEPTH of 1 collapses to a single holding register.
module hdd_step_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic push_dir,
    input  logic pop,
    output logic pop_dir,
    output logic full,
    output logic empty
);

    if (DEPTH == 1) begin : g_hold
        logic held_valid;
        logic held_dir;
        logic do_push;
        logic do_pop;

        assign do_push = push && (!held_valid || pop);
        assign do_pop  = pop && held_valid;
        assign full    = held_valid;
        assign empty   = !held_valid;
        assign pop_dir = held_dir;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                held_valid <= 1'b0;
                held_dir   <= 1'b0;
            end else if (do_push) begin
                held_valid <= 1'b1;
                held_dir   <= push_dir;
            end else if (do_pop) begin
                held_valid <= 1'b0;
            end
        end
    end else begin : g_fifo
        localparam int unsigned AW = $clog2(DEPTH);
        logic [DEPTH-1:0] mem;
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [AW:0]      count;
        logic             do_push;
        logic             do_pop;

        // A push into a full FIFO is allowed when the head leaves the same cycle
        assign do_push = push && (!full || pop);
        assign do_pop  = pop && !empty;
        assign full    = (count == (AW+1)'(DEPTH));
        assign empty   = (count == '0);
        assign pop_dir = mem[rd_ptr];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= push_dir;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (do_push && !do_pop) begin
                    count <= count + (AW+1)'(1);
                end else if (!do_push && do_pop) begin
                    count <= count - (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hdd_step_pulse_gen.sv
// ST-506/ESDI STEP/DIRECTION pulse generator fed by the seek controller.
// HDD_STEP_QUEUE_EN enables a QUEUE_DEPTH-entry request FIFO; otherwise one request is held.
module hdd_step_pulse_gen
    import hdd_step_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_request,
    input  logic             step_direction,
    input  logic             write_gate,
    input  logic [CNT_W-1:0] dir_setup_time,
    input  logic [CNT_W-1:0] step_pulse_width,
    input  logic [CNT_W-1:0] step_recovery,
    output logic             step_out,
    output logic             dir_out,
    output logic             step_done,
    output logic             step_reject,
    output logic             busy,
    output logic [15:0]      pulses_issued
);

    localparam int unsigned EFF_DEPTH = QUEUE_EN ? QUEUE_DEPTH : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             dir_cur;
    logic             cnt_tc;
    logic             done_evt;
    logic             done_q;
    logic             q_pop;
    logic             q_dir;
    logic             q_full;
    logic             q_empty;

    hdd_step_queue #(
        .DEPTH (EFF_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (step_request),
        .push_dir (step_direction),
        .pop      (q_pop),
        .pop_dir  (q_dir),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Terminal at 1 (or a programmed 0) so every state lasts max(value,1) clocks
    assign cnt_tc   = (cnt <= CNT_W'(1));
    assign done_evt = (state == ST_RECOVERY) && cnt_tc;
    assign q_pop    = (state == ST_IDLE) && !q_empty && !write_gate;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dir_cur <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (q_pop) begin
                        if (q_dir != dir_cur) begin
                            dir_cur <= q_dir;
                            cnt     <= dir_setup_time;
                            state   <= ST_DIR_SETUP;
                        end else begin
                            cnt   <= step_pulse_width;
                            state <= ST_PULSE;
                        end
                    end
                end
                ST_DIR_SETUP: begin
                    if (cnt_tc) begin
                        cnt   <= step_pulse_width;
                        state <= ST_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_tc) begin
                        cnt   <= step_recovery;
                        state <= ST_RECOVERY;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt_tc) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Drive-side outputs are registered one clock behind the FSM; done takes a second
    // stage so it trails the STEP fall by exactly the recovery time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_out      <= 1'b0;
            dir_out       <= 1'b0;
            done_q        <= 1'b0;
            step_done     <= 1'b0;
            step_reject   <= 1'b0;
            busy          <= 1'b0;
            pulses_issued <= '0;
        end else begin
            step_out    <= (state == ST_PULSE);
            dir_out     <= dir_cur;
            done_q      <= done_evt;
            step_done   <= done_q;
            step_reject <= step_request && q_full && !q_pop;
            busy        <= (state != ST_IDLE) || !q_empty || done_q;
            if (done_q) begin
                pulses_issued <= pulses_issued + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdd_step_pulse_gen.sv
// Randomised scoreboard bench for hdd_step_pulse_gen; timestamp-based reference model.
module tb_hdd_step_pulse_gen;

    localparam int unsigned QD = 4;
`ifdef HDD_STEP_QUEUE_EN
    localparam int CAP = QD;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step_request;
    logic        step_direction;
    logic        write_gate;
    logic [15:0] dir_setup_time;
    logic [15:0] step_pulse_width;
    logic [15:0] step_recovery;
    logic        step_out;
    logic        dir_out;
    logic        step_done;
    logic        step_reject;
    logic        busy;
    logic [15:0] pulses_issued;

    hdd_step_pulse_gen #(
        .QUEUE_DEPTH (QD),
        .CNT_W       (16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .step_request     (step_request),
        .step_direction   (step_direction),
        .write_gate       (write_gate),
        .dir_setup_time   (dir_setup_time),
        .step_pulse_width (step_pulse_width),
        .step_recovery    (step_recovery),
        .step_out         (step_out),
        .dir_out          (dir_out),
        .step_done        (step_done),
        .step_reject      (step_reject),
        .busy             (busy),
        .pulses_issued    (pulses_issued)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at edge", name, act, exp);
        end
    endfunction

    function automatic int mx1(logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    typedef struct {
        int dir;
        int setup;
        int w;
        int r;
        int rise;
    } exp_t;

    exp_t sb[$];
    int   rej_q[$];
    int   mq[$];
    int   edge_cnt = 0;
    int   free_at  = 0;
    int   m_dir    = 0;

    // Reference model: each popped step occupies the engine for setup+W+R clocks plus one idle clock
    always @(posedge clk) begin
        int   n;
        bit   pop;
        exp_t e;
        edge_cnt++;
        n = edge_cnt;
        if (!reset_n) begin
            sb.delete();
            rej_q.delete();
            mq.delete();
            free_at = 0;
            m_dir   = 0;
        end else begin
            pop = (mq.size() > 0) && !write_gate && (n >= free_at);
            if (pop) begin
                e.dir   = mq.pop_front();
                e.setup = (e.dir != m_dir) ? mx1(dir_setup_time) : 0;
                e.w     = mx1(step_pulse_width);
                e.r     = mx1(step_recovery);
                e.rise  = n + 1 + e.setup;
                m_dir   = e.dir;
                sb.push_back(e);
                free_at = n + e.setup + e.w + e.r + 1;
            end
            if (step_request) begin
                if (mq.size() < CAP) mq.push_back(int'(step_direction));
                else rej_q.push_back(n);
            end
        end
    end

    // Monitor: ph 0 = waiting for STEP, 1 = STEP high, 2 = recovery
    int   ph = 0;
    int   rise_edge, fall_edge, last_dir_chg;
    int   exp_pulses = 0;
    bit   dir_moved;
    logic prev_step = 1'b0;
    logic prev_dir  = 1'b0;
    logic prev_done = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (!reset_n) begin
            ph         = 0;
            prev_step  = 1'b0;
            prev_dir   = 1'b0;
            prev_done  = 1'b0;
            exp_pulses = 0;
        end else begin
            if (dir_out !== prev_dir) begin
                last_dir_chg = edge_cnt;
                if (ph != 0) dir_moved = 1'b1;
            end
            if (step_out && !prev_step) begin
                chk("pulse_after_done", ph, 0);
                chk("pulse_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    chk("rise_cycle", edge_cnt, cur.rise);
                    chk("dir_at_rise", dir_out, cur.dir);
                    if (cur.setup > 0) chk("dir_setup", edge_cnt - last_dir_chg, cur.setup);
                    rise_edge = edge_cnt;
                    dir_moved = 1'b0;
                    ph = 1;
                end
            end
            if (!step_out && prev_step && ph == 1) begin
                chk("pulse_width", edge_cnt - rise_edge, cur.w);
                fall_edge = edge_cnt;
                ph = 2;
            end
            if (step_done) begin
                chk("done_one_cycle", prev_done, 0);
                chk("done_expected", ph, 2);
                if (ph == 2) begin
                    exp_pulses++;
                    chk("recovery", edge_cnt - fall_edge, cur.r);
                    chk("dir_hold", dir_moved, 0);
                    chk("dir_after", dir_out, cur.dir);
                    chk("pulses_issued", pulses_issued, exp_pulses & 16'hFFFF);
                    ph = 0;
                end
            end
            if (step_reject) begin
                chk("reject_expected", rej_q.size() > 0, 1);
                if (rej_q.size() > 0) chk("reject_cycle", edge_cnt, rej_q.pop_front());
            end
            prev_step = step_out;
            prev_dir  = dir_out;
            prev_done = step_done;
        end
    end

    task automatic drive(bit r, bit d);
        @(negedge clk);
        step_request   = r;
        step_direction = d;
    endtask

    task automatic set_timing(int s, int w, int r);
        dir_setup_time   = 16'(s);
        step_pulse_width = 16'(w);
        step_recovery    = 16'(r);
    endtask

    task automatic drain(int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && mq.size() == 0 && ph == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drained", ok, 1);
        chk("rejects_all_seen", rej_q.size(), 0);
    endtask

    task automatic wait_step_high(int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (step_out) begin
                ok = 1'b1;
                break;
            end
        end
        chk("step_seen", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset_n        = 1'b0;
        step_request   = 1'b0;
        step_direction = 1'b0;
        write_gate     = 1'b0;
        set_timing(300, 3000, 1500);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_step_out", step_out, 0);
        chk("rst_dir_out", dir_out, 0);
        chk("rst_step_done", step_done, 0);
        chk("rst_step_reject", step_reject, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", pulses_issued, 0);

        // Single step, matching direction, default timing
        drive(1, 0);
        drive(0, 0);
        drain(10000);

        // Direction change to 1 with setup
        drive(1, 1);
        drive(0, 0);
        drain(10000);

        // Six back-to-back requests, short timing
        set_timing(0, 10, 10);
        for (int i = 0; i < 6; i++) drive(1, 1);
        drive(0, 0);
        drain(1000);

        // write_gate holds off two queued steps, then is raised mid-pulse
        write_gate = 1'b1;
        drive(1, 0);
        drive(1, 0);
        drive(0, 0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (step_out) seen = 1'b1;
        end
        chk("wg_no_step", seen, 0);
        chk("wg_busy", busy, 1);
        write_gate = 1'b0;
        wait_step_high(100);
        repeat (3) @(negedge clk);
        write_gate = 1'b1;
        repeat (30) @(negedge clk);
        write_gate = 1'b0;
        drain(1000);

        // All timing zero: three-clock step period
        set_timing(0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0);
        drive(0, 0);
        drain(500);

        // Randomised batches
        for (int b = 0; b < 4; b++) begin
            set_timing($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 6));
            for (int i = 0; i < 80; i++) begin
                drive(($urandom_range(0, 2) == 0), $urandom_range(0, 1));
                write_gate = ($urandom_range(0, 7) == 0);
            end
            drive(0, 0);
            write_gate = 1'b0;
            drain(2000);
        end

        // Reset mid-pulse with a second request queued
        set_timing(0, 20, 5);
        drive(1, 0);
        drive(1, 0);
        drive(0, 0);
        wait_step_high(100);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_step", step_out, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (step_out || busy || step_done) seen = 1'b1;
        end
        chk("post_reset_quiet", seen, 0);
        chk("post_reset_pulses", pulses_issued, 0);
        chk("post_reset_dir", dir_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
